// File: rtl/inst_mem_responder_pkg.sv
// rtl/inst_mem_responder_pkg.sv - shared types and constants for the instruction memory responder
// Purpose: bundle-level types used by the responder top, its word array and the bench.
//   global_t   : clock and synchronous active-high reset
//   mem_req_t  : fetch request level plus byte address
//   mem_resp_t : one-cycle ready pulse plus instruction word
package inst_mem_responder_pkg;

   typedef struct packed {
      logic clk;
      logic rst;
   } global_t;

   typedef struct packed {
      logic        Req;
      logic [31:0] Address;
   } mem_req_t;

   typedef struct packed {
      logic        Ready;
      logic [31:0] Data;
   } mem_resp_t;

   localparam logic [31:0] INST_NOP = 32'h0;

   typedef enum logic [1:0] {
      IMR_IDLE,
      IMR_WAIT,
      IMR_RESP
   } imr_state_t;

endpackage

// File: rtl/inst_mem_array.sv
// rtl/inst_mem_array.sv - DEPTH x 32 word array, two registered read ports, one write port
// Purpose: instruction word storage. Reads and the write share one edge; a read of the
//          word being written returns the old contents.
// Ports:
//   clk                : rising-edge clock
//   rd0_en/addr/data   : read port 0, data registered and held while rd0_en is low
//   rd1_en/addr/data   : read port 1, same behaviour
//   wr_en/addr/data    : write port
module inst_mem_array #(
   parameter int DEPTH  = 1024,
   parameter int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clk,
   input  logic              rd0_en,
   input  logic [ADDR_W-1:0] rd0_addr,
   output logic [31:0]       rd0_data,
   input  logic              rd1_en,
   input  logic [ADDR_W-1:0] rd1_addr,
   output logic [31:0]       rd1_data,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [31:0]       wr_data
);

   logic [31:0] mem_q [DEPTH];
   logic [31:0] rd0_data_q;
   logic [31:0] rd1_data_q;

   // Non-blocking updates give read-before-write on a same-word collision.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_addr] <= wr_data;
      end
      if (rd0_en) begin
         rd0_data_q <= mem_q[rd0_addr];
      end
      if (rd1_en) begin
         rd1_data_q <= mem_q[rd1_addr];
      end
   end

   assign rd0_data = rd0_data_q;
   assign rd1_data = rd1_data_q;

endmodule

// File: rtl/inst_mem_responder.sv
// rtl/inst_mem_responder.sv - memory-side responder for the two-port instruction fetch protocol
// Purpose: accepts one fetch covering both slots, waits LATENCY cycles, then pulses Ready
//          for each requested slot with the word (or NOP plus Fault for a bad address).
// Ports:
//   System                 : clk, synchronous active-high rst
//   Inst1_Req / Inst2_Req  : request level and byte address for slot 1 / slot 2
//   Flush                  : abort any in-flight fetch, suppress a Ready in this cycle
//   Load_En/Addr/Data      : preload write port, active in any FSM state, blocked in reset
//   Inst1_Resp / Inst2_Resp: one-cycle Ready pulse with instruction data
//   Fault                  : bit0 slot 1, bit1 slot 2, valid with Ready
module inst_mem_responder
   import inst_mem_responder_pkg::*;
#(
   parameter int   DEPTH   = 1024,
   parameter int   LATENCY = 2,
   localparam int  ADDR_W  = $clog2(DEPTH)
) (
   input  global_t           System,
   input  mem_req_t          Inst1_Req,
   input  mem_req_t          Inst2_Req,
   input  logic              Flush,
   input  logic              Load_En,
   input  logic [ADDR_W-1:0] Load_Addr,
   input  logic [31:0]       Load_Data,
   output mem_resp_t         Inst1_Resp,
   output mem_resp_t         Inst2_Resp,
   output logic [1:0]        Fault
);

   localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

   logic        clk;
   logic        rst;
   imr_state_t  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [1:0]  req_q, req_d;
   logic [31:0] addr1_q, addr1_d;
   logic [31:0] addr2_q, addr2_d;
   logic [1:0]  fault_q, fault_d;
   // nop_q forces a slot's Data to NOP; it only changes on a read edge so Data holds afterwards.
   logic [1:0]  nop_q, nop_d;
   logic [1:0]  bad;
   logic        rd_en;
   logic        resp_ok;
   logic [31:0] rd1_data;
   logic [31:0] rd2_data;

   assign clk = System.clk;
   assign rst = System.rst;

   // Misaligned or beyond the array both map to a faulted NOP.
   function automatic logic addr_bad(input logic [31:0] a);
      return (a[1:0] != 2'b00) || ((a >> (ADDR_W + 2)) != 32'h0);
   endfunction

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      req_d   = req_q;
      addr1_d = addr1_q;
      addr2_d = addr2_q;
      fault_d = fault_q;
      nop_d   = nop_q;
      rd_en   = 1'b0;
      bad     = {addr_bad(addr2_q), addr_bad(addr1_q)};
      if (Flush) begin
         // Flush beats acceptance and cancels the read so Data is left untouched.
         state_d = IMR_IDLE;
         cnt_d   = 4'd0;
      end else begin
         case (state_q)
            IMR_IDLE: begin
               if (Inst1_Req.Req || Inst2_Req.Req) begin
                  req_d   = {Inst2_Req.Req, Inst1_Req.Req};
                  addr1_d = Inst1_Req.Address;
                  addr2_d = Inst2_Req.Address;
                  cnt_d   = CNT_INIT;
                  state_d = IMR_WAIT;
               end
            end
            IMR_WAIT: begin
               if (cnt_q == 4'd0) begin
                  rd_en   = 1'b1;
                  fault_d = req_q & bad;
                  nop_d   = ~req_q | bad;
                  state_d = IMR_RESP;
               end else begin
                  cnt_d = cnt_q - 4'd1;
               end
            end
            IMR_RESP: begin
               state_d = IMR_IDLE;
            end
            default: begin
               state_d = IMR_IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IMR_IDLE;
         cnt_q   <= 4'd0;
         req_q   <= 2'b00;
         addr1_q <= 32'h0;
         addr2_q <= 32'h0;
         fault_q <= 2'b00;
         nop_q   <= 2'b11;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         req_q   <= req_d;
         addr1_q <= addr1_d;
         addr2_q <= addr2_d;
         fault_q <= fault_d;
         nop_q   <= nop_d;
      end
   end

   inst_mem_array #(
      .DEPTH  (DEPTH),
      .ADDR_W (ADDR_W)
   ) u_array (
      .clk      (clk),
      .rd0_en   (rd_en && !rst && !nop_d[0]),
      .rd0_addr (addr1_q[ADDR_W+1:2]),
      .rd0_data (rd1_data),
      .rd1_en   (rd_en && !rst && !nop_d[1]),
      .rd1_addr (addr2_q[ADDR_W+1:2]),
      .rd1_data (rd2_data),
      .wr_en    (Load_En && !rst),
      .wr_addr  (Load_Addr),
      .wr_data  (Load_Data)
   );

   // Flush during RESP kills the pulse in the same cycle.
   assign resp_ok    = (state_q == IMR_RESP) && !Flush;
   assign Inst1_Resp = '{Ready: resp_ok && req_q[0], Data: nop_q[0] ? INST_NOP : rd1_data};
   assign Inst2_Resp = '{Ready: resp_ok && req_q[1], Data: nop_q[1] ? INST_NOP : rd2_data};
   assign Fault      = resp_ok ? fault_q : 2'b00;

endmodule

// File: tb/tb_inst_mem_responder.sv
// tb/tb_inst_mem_responder.sv - self-checking bench for inst_mem_responder
module tb_inst_mem_responder;
   import inst_mem_responder_pkg::*;

   localparam int DEPTH  = 1024;
   localparam int L      = 2;
   localparam int ADDR_W = $clog2(DEPTH);

   logic              clk = 1'b0;
   logic              rst;
   global_t           System;
   mem_req_t          i1, i2;
   logic              Flush;
   logic              Load_En;
   logic [ADDR_W-1:0] Load_Addr;
   logic [31:0]       Load_Data;
   mem_resp_t         o1, o2;
   logic [1:0]        Fault;

   int n_assert = 0;
   int n_fail   = 0;

   logic [31:0] ref_mem [DEPTH];

   assign System = '{clk: clk, rst: rst};
   always #5 clk = ~clk;

   inst_mem_responder #(.DEPTH(DEPTH), .LATENCY(L)) dut (
      .System     (System),
      .Inst1_Req  (i1),
      .Inst2_Req  (i2),
      .Flush      (Flush),
      .Load_En    (Load_En),
      .Load_Addr  (Load_Addr),
      .Load_Data  (Load_Data),
      .Inst1_Resp (o1),
      .Inst2_Resp (o2),
      .Fault      (Fault)
   );

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] rdy();
      return {30'b0, o2.Ready, o1.Ready};
   endfunction

   function automatic logic slot_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'(DEPTH * 4));
   endfunction

   function automatic logic [31:0] exp_data(input logic [31:0] a, input logic r);
      if (!r || slot_bad(a)) return 32'h0;
      return ref_mem[a / 4];
   endfunction

   function automatic logic [31:0] valid_addr();
      return 32'($urandom_range(0, DEPTH - 1)) * 4;
   endfunction

   task automatic load(input int idx, input logic [31:0] d);
      Load_En   = 1'b1;
      Load_Addr = ADDR_W'(idx);
      Load_Data = d;
      cyc();
      Load_En   = 1'b0;
      ref_mem[idx] = d;
   endtask

   task automatic fetch(input string tag, input logic [31:0] a1, input logic r1,
                        input logic [31:0] a2, input logic r2);
      logic [31:0] d1, d2;
      logic [1:0]  f;
      d1 = exp_data(a1, r1);
      d2 = exp_data(a2, r2);
      f  = {r2 && slot_bad(a2), r1 && slot_bad(a1)};
      i1 = '{r1, a1};
      i2 = '{r2, a2};
      cyc();
      i1 = '{1'b0, $urandom};
      i2 = '{1'b0, $urandom};
      for (int k = 1; k < L; k++) begin
         cyc();
         chk({tag, " wait ready"}, rdy(), 32'h0);
      end
      cyc();
      chk({tag, " ready"}, rdy(), {30'b0, r2, r1});
      chk({tag, " data1"}, o1.Data, d1);
      chk({tag, " data2"}, o2.Data, d2);
      chk({tag, " fault"}, {30'b0, Fault}, {30'b0, f});
      cyc();
      chk({tag, " after ready"}, rdy(), 32'h0);
      chk({tag, " after fault"}, {30'b0, Fault}, 32'h0);
      chk({tag, " hold data1"}, o1.Data, d1);
      chk({tag, " hold data2"}, o2.Data, d2);
   endtask

   initial begin
      logic [31:0] hist1 [3*(L+2)];
      logic [31:0] hist2 [3*(L+2)];
      logic [31:0] a1, a2, old_w, new_w, word5;
      logic        r1, r2, exp_rdy;
      int          pulses;

      rst = 1'b1; Flush = 1'b0; Load_En = 1'b0; Load_Addr = '0; Load_Data = '0;
      i1 = '{1'b0, 32'h0};
      i2 = '{1'b0, 32'h0};
      repeat (3) cyc();
      chk("reset ready", rdy(), 32'h0);
      chk("reset data1", o1.Data, 32'h0);
      chk("reset data2", o2.Data, 32'h0);
      chk("reset fault", {30'b0, Fault}, 32'h0);
      rst = 1'b0;
      cyc();

      for (int k = 0; k < DEPTH; k++) load(k, $urandom);
      load(0, 32'h2008_0005);
      load(1, 32'h2009_0007);
      load(2, 32'hDEAD_BEEF);
      word5 = ref_mem[5];

      fetch("latency", 32'h0, 1'b1, 32'h4, 1'b1);
      chk("latency const1", ref_mem[0], 32'h2008_0005);
      fetch("single", 32'h0, 1'b0, 32'h8, 1'b1);
      fetch("fault", 32'h2, 1'b1, 32'h0001_0000, 1'b1);

      // Flush in WAIT: no pulse, then normal service.
      i1 = '{1'b1, 32'h8};
      cyc();
      i1.Req = 1'b0;
      Flush  = 1'b1;
      cyc();
      Flush  = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
         chk("flush wait ready", rdy(), 32'h0);
         cyc();
      end
      fetch("after flush", 32'h8, 1'b1, 32'h4, 1'b1);

      // Flush together with Req in IDLE: no acceptance.
      i1 = '{1'b1, 32'h0};
      Flush = 1'b1;
      cyc();
      i1.Req = 1'b0;
      Flush  = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
         cyc();
         chk("flush idle ready", rdy(), 32'h0);
      end

      // Flush during RESP suppresses the pulse combinationally.
      i1 = '{1'b1, 32'h0};
      cyc();
      i1.Req = 1'b0;
      for (int k = 1; k < L; k++) cyc();
      cyc();
      Flush = 1'b1;
      #1;
      chk("flush resp ready", rdy(), 32'h0);
      chk("flush resp fault", {30'b0, Fault}, 32'h0);
      cyc();
      Flush = 1'b0;
      chk("flush resp after", rdy(), 32'h0);
      cyc();

      // Held Req with addresses changing every cycle: acceptances every L+2 edges.
      pulses = 0;
      for (int n = 0; n < 3 * (L + 2); n++) begin
         hist1[n] = valid_addr();
         hist2[n] = valid_addr();
         i1 = '{1'b1, hist1[n]};
         i2 = '{1'b1, hist2[n]};
         cyc();
         exp_rdy = ((n % (L + 2)) == L);
         chk("held ready", rdy(), exp_rdy ? 32'h3 : 32'h0);
         if (exp_rdy) begin
            chk("held data1", o1.Data, ref_mem[hist1[n-L] / 4]);
            chk("held data2", o2.Data, ref_mem[hist2[n-L] / 4]);
         end
         if (o1.Ready) pulses++;
      end
      i1.Req = 1'b0;
      i2.Req = 1'b0;
      chk("held pulse count", 32'(pulses), 32'd3);
      cyc();

      // Reset in WAIT, with a load attempt that must be blocked.
      i1 = '{1'b1, 32'd20};
      i2 = '{1'b1, 32'h0};
      cyc();
      i1.Req = 1'b0;
      i2.Req = 1'b0;
      rst = 1'b1;
      Load_En = 1'b1; Load_Addr = ADDR_W'(5); Load_Data = ~word5;
      cyc();
      chk("midrst ready", rdy(), 32'h0);
      chk("midrst data1", o1.Data, 32'h0);
      chk("midrst data2", o2.Data, 32'h0);
      chk("midrst fault", {30'b0, Fault}, 32'h0);
      cyc();
      rst = 1'b0;
      Load_En = 1'b0;
      for (int k = 0; k < L + 2; k++) begin
         cyc();
         chk("post rst ready", rdy(), 32'h0);
      end
      fetch("post rst", 32'd20, 1'b1, 32'h0, 1'b0);
      chk("blocked load", ref_mem[5], word5);

      // Load on the read edge returns the old word.
      old_w = ref_mem[0];
      new_w = ~old_w;
      i1 = '{1'b1, 32'h0};
      cyc();
      i1.Req = 1'b0;
      for (int k = 1; k < L; k++) cyc();
      Load_En = 1'b1; Load_Addr = '0; Load_Data = new_w;
      cyc();
      Load_En = 1'b0;
      chk("hazard ready", rdy(), 32'h1);
      chk("hazard old", o1.Data, old_w);
      ref_mem[0] = new_w;
      cyc();
      fetch("hazard new", 32'h0, 1'b1, 32'h4, 1'b1);

      // Randomized fetches against the model.
      for (int t = 0; t < 40; t++) begin
         r1 = 1'($urandom);
         r2 = 1'($urandom);
         if (!r1 && !r2) r1 = 1'b1;
         a1 = valid_addr();
         a2 = valid_addr();
         case ($urandom % 4)
            0: a1 = a1 + 32'($urandom_range(1, 3));
            1: a2 = a2 | (32'h1 << $urandom_range(ADDR_W + 2, 31));
            default: ;
         endcase
         if ($urandom % 2) load($urandom_range(0, DEPTH - 1), $urandom);
         fetch("random", a1, r1, a2, r2);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
